riscv_ll_writeback_unit: RTL

//  Parametrised long-latency writeback merger for the integer regfile write port.
//  - Merges dmem load responses with NUM_CH buffered unit result channels (mul, div, fpu-to-int, ...).
//  - Drives one registered ll write port; FP-destined loads go to a separate fpu_ld port.
//  - Sits between the execute-side long-latency units and the regfile/scoreboard clear logic.

---
 rtl/riscv_wb_pkg.sv | 41 ++++
 rtl/riscv_ll_writeback_unit_if.sv | 50 +++++
 rtl/riscv_ll_wb_fifo.sv | 73 +++++++
 rtl/riscv_ll_writeback_unit.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_wb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : riscv_wb_pkg                                                   |
// | Purpose   : Shared constants for the long-latency writeback merger:        |
// |             memory access type encodings, FP load precision codes,         |
// |             dmem response tag field offsets and arbiter mode selectors.    |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package riscv_wb_pkg;

   // Memory access types carried in the dmem response tag
   typedef enum logic [2:0] {
      MT_B  = 3'b000,
      MT_H  = 3'b001,
      MT_W  = 3'b010,
      MT_D  = 3'b011,
      MT_BU = 3'b100,
      MT_HU = 3'b101,
      MT_WU = 3'b110
   } mem_type_e;

   localparam logic PRECISION_S = 1'b0;
   localparam logic PRECISION_D = 1'b1;

   // dmem tag layout: {xf, type[2:0], pos[POS_W-1:0], waddr[4:0]}
   localparam int TAG_WADDR_LSB = 0;
   localparam int TAG_POS_LSB   = 5;

   function automatic int tag_type_lsb(input int pos_w);
      return TAG_POS_LSB + pos_w;
   endfunction

   function automatic int tag_xf_bit(input int pos_w);
      return TAG_POS_LSB + pos_w + 3;
   endfunction

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

endpackage
`default_nettype wire

// File: rtl/riscv_ll_writeback_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : riscv_ll_writeback_unit_if                                     |
// | Purpose   : Bundles the dmem response, the per-channel result enqueue      |
// |             ports and the ll / fpu_ld writeback ports of the merger.       |
// |   master : producer/consumer side (drives dmem + channel enqueues)         |
// |   slave  : merger side (drives rdy/deq, ll_*, fpu_ld_*, ovf_err)           |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface riscv_ll_writeback_unit_if #(
   parameter int XLEN   = 64,
   parameter int NUM_CH = 3,
   parameter int POS_W  = $clog2(XLEN / 8)
);
   logic                     dmem_resp_val;
   logic [XLEN-1:0]          dmem_resp_data;
   logic [POS_W+8:0]         dmem_resp_tag;
   logic [NUM_CH-1:0]        ch_enq_val;
   logic [NUM_CH*XLEN-1:0]   ch_enq_bits;
   logic [NUM_CH*5-1:0]      ch_enq_tag;
   logic [NUM_CH-1:0]        ch_enq_rdy;
   logic [NUM_CH-1:0]        ch_deq;
   logic                     ll_wen;
   logic [4:0]               ll_waddr;
   logic [XLEN-1:0]          ll_wdata;
   logic                     fpu_ld_val;
   logic [4:0]               fpu_ld_rd;
   logic [XLEN-1:0]          fpu_ld_data;
   logic                     fpu_ld_precision;
   logic                     ovf_err;

   modport master (
      output dmem_resp_val, dmem_resp_data, dmem_resp_tag,
      output ch_enq_val, ch_enq_bits, ch_enq_tag,
      input  ch_enq_rdy, ch_deq,
      input  ll_wen, ll_waddr, ll_wdata,
      input  fpu_ld_val, fpu_ld_rd, fpu_ld_data, fpu_ld_precision,
      input  ovf_err
   );

   modport slave (
      input  dmem_resp_val, dmem_resp_data, dmem_resp_tag,
      input  ch_enq_val, ch_enq_bits, ch_enq_tag,
      output ch_enq_rdy, ch_deq,
      output ll_wen, ll_waddr, ll_wdata,
      output fpu_ld_val, fpu_ld_rd, fpu_ld_data, fpu_ld_precision,
      output ovf_err
   );
endinterface
`default_nettype wire

// File: rtl/riscv_ll_wb_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : riscv_ll_wb_fifo                                               |
// | Purpose   : Small result FIFO for one long-latency channel.                |
// | Ports     : clk, reset_n (async, active-low)                               |
// |             enq_val_i/enq_data_i : push request                            |
// |             deq_i                : pop request (ignored when empty)        |
// |             head_o               : oldest entry                            |
// |             empty_o / count_o    : occupancy                               |
// |             drop_o               : push refused (full, no same-cycle pop)  |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module riscv_ll_wb_fifo #(
   parameter int WIDTH = 69,
   parameter int DEPTH = 2
) (
   input  wire logic                     clk,
   input  wire logic                     reset_n,
   input  wire logic                     enq_val_i,
   input  wire logic [WIDTH-1:0]         enq_data_i,
   input  wire logic                     deq_i,
   output      logic [WIDTH-1:0]         head_o,
   output      logic                     empty_o,
   output      logic [$clog2(DEPTH):0]   count_o,
   output      logic                     drop_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   cnt_q, cnt_d;
   logic             full;
   logic             do_enq;
   logic             do_deq;

   assign empty_o = (cnt_q == '0);
   assign full    = (cnt_q == CNT_FULL);
   assign count_o = cnt_q;
   assign head_o  = mem_q[rd_ptr_q];

   always_comb begin
      do_deq   = deq_i & ~empty_o;
      // A pop in the same cycle frees the slot the push needs
      do_enq   = enq_val_i & (~full | do_deq);
      drop_o   = enq_val_i & full & ~do_deq;
      rd_ptr_d = rd_ptr_q + PTR_W'(do_deq);
      wr_ptr_d = wr_ptr_q + PTR_W'(do_enq);
      cnt_d    = cnt_q + (PTR_W + 1)'(do_enq) - (PTR_W + 1)'(do_deq);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset: an entry is only read after it was written
   always_ff @(posedge clk) begin
      if (do_enq) begin
         mem_q[wr_ptr_q] <= enq_data_i;
      end
   end

endmodule
`default_nettype wire

// File: rtl/riscv_ll_writeback_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : riscv_ll_writeback_unit                                        |
// | Purpose   : Merges dmem load responses with NUM_CH buffered long-latency   |
// |             unit results onto one registered integer regfile write port;  |
// |             FP-destined loads leave on a separate fpu_ld port.            |
// | Ports     : clk, reset_n (async, active-low)                               |
// |             wb (slave modport of riscv_ll_writeback_unit_if):              |
// |               dmem_resp_*  load response (never stalled)                   |
// |               ch_enq_*     per-channel result enqueue, ch_enq_rdy = ~full  |
// |               ch_deq       one-hot grant pulse                             |
// |               ll_*         registered regfile write port                   |
// |               fpu_ld_*     registered FP load writeback                    |
// |               ovf_err      sticky enqueue-drop flag                        |
// | Config    : LL_WB_BYPASS_EN - grant a channel straight from its enqueue    |
// |             port when its FIFO is empty (one cycle lower latency).         |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module riscv_ll_writeback_unit
   import riscv_wb_pkg::*;
#(
   parameter int XLEN     = 64,
   parameter int NUM_CH   = 3,
   parameter int DEPTH    = 2,
   parameter int ARB_MODE = ARB_RR,
   parameter int POS_W    = $clog2(XLEN / 8)
) (
   input wire logic                 clk,
   input wire logic                 reset_n,
   riscv_ll_writeback_unit_if.slave wb
);
   localparam int ENT_W    = XLEN + 5;
   localparam int PTR_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_W    = $clog2(DEPTH) + 1;
   localparam int TYPE_LSB = tag_type_lsb(POS_W);
   localparam int XF_BIT   = tag_xf_bit(POS_W);

   // ---------------------------------------------------------------- dmem decode
   logic             ld_xf;
   logic [2:0]       ld_type;
   logic [POS_W-1:0] ld_pos;
   logic [4:0]       ld_waddr;
   logic             preempt;
   logic             fp_ld;

   assign ld_xf    = wb.dmem_resp_tag[XF_BIT];
   assign ld_type  = wb.dmem_resp_tag[TYPE_LSB +: 3];
   assign ld_pos   = wb.dmem_resp_tag[TAG_POS_LSB +: POS_W];
   assign ld_waddr = wb.dmem_resp_tag[TAG_WADDR_LSB +: 5];
   assign preempt  = wb.dmem_resp_val & ~ld_xf;
   assign fp_ld    = wb.dmem_resp_val & ld_xf;

   // ------------------------------------------------------------ load formatter
   // pos is a byte offset; aligning it down to the access size and shifting
   // by that many bytes selects the word/half/byte (pos MSB picks the word).
   logic [XLEN-1:0]  ld_data;
   logic [XLEN-1:0]  sh_b, sh_h, sh_w;
   logic [POS_W-1:0] pos_h, pos_w;

   always_comb begin
      pos_h = ld_pos & ~POS_W'(1);
      pos_w = ld_pos & ~POS_W'(3);
      sh_b  = wb.dmem_resp_data >> {ld_pos, 3'b000};
      sh_h  = wb.dmem_resp_data >> {pos_h, 3'b000};
      sh_w  = wb.dmem_resp_data >> {pos_w, 3'b000};
      case (ld_type)
         MT_B:    ld_data = XLEN'($signed(sh_b[7:0]));
         MT_H:    ld_data = XLEN'($signed(sh_h[15:0]));
         MT_W:    ld_data = XLEN'($signed(sh_w[31:0]));
         MT_BU:   ld_data = XLEN'(sh_b[7:0]);
         MT_HU:   ld_data = XLEN'(sh_h[15:0]);
         MT_WU:   ld_data = XLEN'(sh_w[31:0]);
         MT_D:    ld_data = (XLEN == 64) ? wb.dmem_resp_data : '0;
         default: ld_data = '0;
      endcase
   end

   // ----------------------------------------------------------- channel FIFOs
   logic [NUM_CH-1:0] empty;
   logic [NUM_CH-1:0] drop;
   logic [NUM_CH-1:0] fifo_enq;
   logic [NUM_CH-1:0] fifo_deq;
   logic [NUM_CH-1:0] req;
   logic [NUM_CH-1:0] gnt;
   logic [NUM_CH-1:0] byp;
   logic [ENT_W-1:0]  head    [NUM_CH];
   logic [ENT_W-1:0]  enq_ent [NUM_CH];
   logic [CNT_W-1:0]  count   [NUM_CH];

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign enq_ent[i]       = {wb.ch_enq_tag[i*5 +: 5], wb.ch_enq_bits[i*XLEN +: XLEN]};
      assign wb.ch_enq_rdy[i] = (count[i] != CNT_W'(DEPTH));

      riscv_ll_wb_fifo #(
         .WIDTH (ENT_W),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk        (clk),
         .reset_n    (reset_n),
         .enq_val_i  (fifo_enq[i]),
         .enq_data_i (enq_ent[i]),
         .deq_i      (fifo_deq[i]),
         .head_o     (head[i]),
         .empty_o    (empty[i]),
         .count_o    (count[i]),
         .drop_o     (drop[i])
      );
   end

`ifdef LL_WB_BYPASS_EN
   // An empty channel may compete with the entry it is enqueueing right now;
   // when granted that entry skips the FIFO.
   assign req = ~empty | wb.ch_enq_val;
   assign byp = gnt & empty;
`else
   assign req = ~empty;
   assign byp = '0;
`endif

   assign fifo_deq  = gnt & ~empty;
   assign fifo_enq  = wb.ch_enq_val & ~byp;
   assign wb.ch_deq = gnt;

   // ---------------------------------------------------------------- arbiter
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic [PTR_W-1:0] gnt_idx;
   logic [PTR_W-1:0] cand;
   logic             any_gnt;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      cand    = '0;
      any_gnt = 1'b0;
      if (!preempt) begin
         for (int off = 0; off < NUM_CH; off++) begin
            if (ARB_MODE == ARB_RR) begin
               cand = PTR_W'((int'(ptr_q) + off) % NUM_CH);
            end else begin
               cand = PTR_W'(off);
            end
            if (!any_gnt && req[cand]) begin
               any_gnt   = 1'b1;
               gnt[cand] = 1'b1;
               gnt_idx   = cand;
            end
         end
      end
   end

   logic [ENT_W-1:0] sel;

   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (gnt[i]) begin
            sel = empty[i] ? enq_ent[i] : head[i];
         end
      end
   end

   // ------------------------------------------------------- output registers
   logic            ll_wen_q,   ll_wen_d;
   logic [4:0]      ll_waddr_q, ll_waddr_d;
   logic [XLEN-1:0] ll_wdata_q, ll_wdata_d;
   logic            fpu_val_q,  fpu_val_d;
   logic [4:0]      fpu_rd_q,   fpu_rd_d;
   logic [XLEN-1:0] fpu_data_q, fpu_data_d;
   logic            fpu_prec_q, fpu_prec_d;
   logic            ovf_q,      ovf_d;

   always_comb begin
      // ll address/data hold their last value when nothing is written
      ll_wen_d   = preempt | any_gnt;
      ll_waddr_d = ll_waddr_q;
      ll_wdata_d = ll_wdata_q;
      if (preempt) begin
         ll_waddr_d = ld_waddr;
         ll_wdata_d = ld_data;
      end else if (any_gnt) begin
         ll_waddr_d = sel[XLEN +: 5];
         ll_wdata_d = sel[XLEN-1:0];
      end

      fpu_val_d  = fp_ld;
      fpu_rd_d   = fpu_rd_q;
      fpu_data_d = fpu_data_q;
      fpu_prec_d = fpu_prec_q;
      if (fp_ld) begin
         fpu_rd_d   = ld_waddr;
         fpu_data_d = ld_data;
         fpu_prec_d = (ld_type == MT_D) ? PRECISION_D : PRECISION_S;
      end

      ovf_d = ovf_q | (|drop);

      ptr_d = ptr_q;
      if ((ARB_MODE == ARB_RR) && any_gnt) begin
         ptr_d = PTR_W'((int'(gnt_idx) + 1) % NUM_CH);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ll_wen_q   <= 1'b0;
         ll_waddr_q <= '0;
         ll_wdata_q <= '0;
         fpu_val_q  <= 1'b0;
         fpu_rd_q   <= '0;
         fpu_data_q <= '0;
         fpu_prec_q <= 1'b0;
         ovf_q      <= 1'b0;
         ptr_q      <= '0;
      end else begin
         ll_wen_q   <= ll_wen_d;
         ll_waddr_q <= ll_waddr_d;
         ll_wdata_q <= ll_wdata_d;
         fpu_val_q  <= fpu_val_d;
         fpu_rd_q   <= fpu_rd_d;
         fpu_data_q <= fpu_data_d;
         fpu_prec_q <= fpu_prec_d;
         ovf_q      <= ovf_d;
         ptr_q      <= ptr_d;
      end
   end

   assign wb.ll_wen           = ll_wen_q;
   assign wb.ll_waddr         = ll_waddr_q;
   assign wb.ll_wdata         = ll_wdata_q;
   assign wb.fpu_ld_val       = fpu_val_q;
   assign wb.fpu_ld_rd        = fpu_rd_q;
   assign wb.fpu_ld_data      = fpu_data_q;
   assign wb.fpu_ld_precision = fpu_prec_q;
   assign wb.ovf_err          = ovf_q;

endmodule
`default_nettype wire
